// File: rtl/matrix_stream_parser.sv
// UART matrix-entry parser: reads "M N e0 e1 ... <CR>", allocates a slot, streams
// elements into BRAM, zero-fills short input and commits the slot.
module matrix_stream_parser #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int DIM_WIDTH     = 4,
  parameter bit SIGNED_EN     = 1'b1,
  parameter bit ECHO_EN       = 1'b0,
  parameter int ALLOC_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active,
  input  logic [DIM_WIDTH-1:0]     cfg_max_dim,
  input  logic [ELEMENT_WIDTH-1:0] cfg_max_value,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     alloc_req,
  output logic [DIM_WIDTH-1:0]     alloc_m,
  output logic [DIM_WIDTH-1:0]     alloc_n,
  input  logic [DIM_WIDTH-1:0]     alloc_slot,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  input  logic                     alloc_valid,
  output logic                     commit_req,
  output logic [DIM_WIDTH-1:0]     commit_slot,
  output logic [DIM_WIDTH-1:0]     commit_m,
  output logic [DIM_WIDTH-1:0]     commit_n,
  output logic [ADDR_WIDTH-1:0]    commit_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [3:0]               error_code,
  output logic [3:0]               sub_state
);
  localparam int ACC_W = ELEMENT_WIDTH + 4;
  localparam int MUL_W = ACC_W + 4;
  localparam int TOT_W = 2 * DIM_WIDTH;
  localparam int TMR_W = $clog2(ALLOC_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, PARSE_M = 4'd1, PARSE_N = 4'd2, CHECK_DIM = 4'd3, WAIT_ALLOC = 4'd4,
    PARSE_DATA = 4'd5, FILL_ZEROS = 4'd6, COMMIT = 4'd7, DONE = 4'd8, ERROR = 4'd9
  } state_t;

  state_t state_reg, state_next;

  logic [ACC_W-1:0]      acc_reg;
  logic                  ovf_reg, neg_reg, tok_reg;
  logic [DIM_WIDTH-1:0]  m_reg, n_reg;
  logic [TOT_W-1:0]      total_reg, written_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [TMR_W-1:0]      timer_reg;

  logic is_digit, is_sep, is_eol, is_esc, is_minus, rx_take;
  logic [MUL_W-1:0]         acc_mul;
  logic [DIM_WIDTH-1:0]     dim_val;
  logic                     val_bad, dim_bad, tok_end, last_write;
  logic [TOT_W-1:0]         written_after;
  logic [ELEMENT_WIDTH-1:0] mag, wr_val;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C);
  assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_esc   = (rx_data == 8'h1B);
  assign is_minus = (rx_data == 8'h2D);
  // Bytes arriving in non-parsing states (fill, commit, alloc wait) are dropped.
  assign rx_take  = rx_done && mode_active &&
                    ((state_reg == PARSE_M) || (state_reg == PARSE_N) ||
                     (state_reg == PARSE_DATA) || (state_reg == ERROR));

  assign acc_mul = ({4'b0, acc_reg} << 3) + ({4'b0, acc_reg} << 1) + MUL_W'(rx_data[3:0]);
  assign dim_val = (ovf_reg || neg_reg || (|acc_reg[ACC_W-1:DIM_WIDTH])) ? '0
                                                                          : acc_reg[DIM_WIDTH-1:0];
  assign dim_bad = (m_reg == '0) || (n_reg == '0) || (m_reg > cfg_max_dim) || (n_reg > cfg_max_dim);
  assign val_bad = ovf_reg || (acc_reg > {4'b0, cfg_max_value});
  assign tok_end = rx_take && (is_sep || is_eol) && tok_reg;
  assign last_write    = (written_reg + TOT_W'(1)) == total_reg;
  assign written_after = written_reg + TOT_W'(tok_reg);
  assign mag    = acc_reg[ELEMENT_WIDTH-1:0];
  assign wr_val = neg_reg ? (~mag + ELEMENT_WIDTH'(1)) : mag;

  assign busy      = (state_reg != IDLE);
  assign sub_state = state_reg;
  assign alloc_m   = m_reg;
  assign alloc_n   = n_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!mode_active) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = PARSE_M;
        PARSE_M: if (rx_take && is_esc) state_next = IDLE;
                 else if (rx_take && is_sep && tok_reg) state_next = PARSE_N;
        PARSE_N: if (rx_take && is_esc) state_next = IDLE;
                 else if (rx_take && is_sep && tok_reg) state_next = CHECK_DIM;
        CHECK_DIM: state_next = dim_bad ? ERROR : WAIT_ALLOC;
        WAIT_ALLOC:
          if (alloc_valid) state_next = PARSE_DATA;
          else if (timer_reg == TMR_W'(ALLOC_TIMEOUT - 1)) state_next = ERROR;
        PARSE_DATA:
          if (rx_take && is_esc) state_next = IDLE;
          else if (tok_end && val_bad) state_next = ERROR;
          else if (rx_take && is_eol) state_next = (written_after < total_reg) ? FILL_ZEROS : COMMIT;
          else if (tok_end && last_write) state_next = COMMIT;
        FILL_ZEROS: if (last_write) state_next = COMMIT;
        COMMIT:     state_next = DONE;
        DONE:       state_next = IDLE;
        ERROR:      if (rx_take && is_esc) state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0; ovf_reg <= 1'b0; neg_reg <= 1'b0; tok_reg <= 1'b0;
      m_reg <= '0; n_reg <= '0; total_reg <= '0; written_reg <= '0;
      base_reg <= '0; timer_reg <= '0;
      tx_data <= '0; tx_start <= 1'b0; alloc_req <= 1'b0;
      commit_req <= 1'b0; commit_slot <= '0; commit_m <= '0; commit_n <= '0; commit_addr <= '0;
      mem_wr_en <= 1'b0; mem_wr_addr <= '0; mem_wr_data <= '0;
      done_pulse <= 1'b0; error_code <= '0;
    end else begin
      mem_wr_en  <= 1'b0;
      commit_req <= 1'b0;
      done_pulse <= 1'b0;
      tx_start   <= 1'b0;
      if (ECHO_EN && rx_take && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= rx_data;
      end
      if (!mode_active) begin
        alloc_req  <= 1'b0;
        error_code <= '0;
        tok_reg    <= 1'b0;
      end else begin
        // Token accumulator shared by the dimension and data states.
        if (rx_take && (state_reg != ERROR)) begin
          if (is_digit) begin
            acc_reg <= acc_mul[ACC_W-1:0];
            ovf_reg <= ovf_reg | (|acc_mul[MUL_W-1:ACC_W]);
            tok_reg <= 1'b1;
          end else if (is_minus) begin
            if (state_reg != PARSE_DATA) begin
              neg_reg <= 1'b1;
              tok_reg <= 1'b1;
            end else if (SIGNED_EN && !tok_reg) begin
              neg_reg <= 1'b1;
              tok_reg <= 1'b1;
            end
          end else if (is_sep || is_eol) begin
            acc_reg <= '0; ovf_reg <= 1'b0; neg_reg <= 1'b0; tok_reg <= 1'b0;
          end
        end
        case (state_reg)
          IDLE: begin
            acc_reg <= '0; ovf_reg <= 1'b0; neg_reg <= 1'b0; tok_reg <= 1'b0;
            written_reg <= '0; timer_reg <= '0;
          end
          PARSE_M: if (rx_take && is_sep && tok_reg) m_reg <= dim_val;
          PARSE_N: if (rx_take && is_sep && tok_reg) n_reg <= dim_val;
          CHECK_DIM: begin
            if (dim_bad) begin
              error_code <= 4'd1;
            end else begin
              total_reg <= TOT_W'(m_reg) * TOT_W'(n_reg);
              alloc_req <= 1'b1;
            end
          end
          WAIT_ALLOC: begin
            if (alloc_valid) begin
              commit_slot <= alloc_slot;
              base_reg    <= alloc_addr;
              alloc_req   <= 1'b0;
            end else if (timer_reg == TMR_W'(ALLOC_TIMEOUT - 1)) begin
              alloc_req  <= 1'b0;
              error_code <= 4'd3;
            end else begin
              timer_reg <= timer_reg + TMR_W'(1);
            end
          end
          PARSE_DATA: begin
            if (tok_end && val_bad) begin
              error_code <= 4'd2;
            end else if (tok_end && (written_reg < total_reg)) begin
              mem_wr_en   <= 1'b1;
              mem_wr_addr <= base_reg + ADDR_WIDTH'(written_reg);
              mem_wr_data <= wr_val;
              written_reg <= written_reg + TOT_W'(1);
            end
          end
          FILL_ZEROS: begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= base_reg + ADDR_WIDTH'(written_reg);
            mem_wr_data <= '0;
            written_reg <= written_reg + TOT_W'(1);
          end
          COMMIT: begin
            commit_req  <= 1'b1;
            commit_m    <= m_reg;
            commit_n    <= n_reg;
            commit_addr <= base_reg;
          end
          DONE:  done_pulse <= 1'b1;
          ERROR: if (rx_take && is_esc) error_code <= '0;
          default: ;
        endcase
      end
    end
  end
endmodule
